// File: rtl/handler_axil_pkg.sv
// handler_axil_pkg
//   Shared definitions for the Handler AXI4-Lite register-file slave:
//   response codes, register kinds, address-to-index and strobe-to-mask
//   helpers. Helpers take the widest legal operands; callers zero-extend
//   their addresses/strobes and truncate the results.
package handler_axil_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam int unsigned ADDR_MAX_W = 32;
  localparam int unsigned DATA_MAX_W = 64;
  localparam int unsigned STRB_MAX_W = DATA_MAX_W / 8;

  typedef enum logic [1:0] {
    KIND_RW  = 2'd0,
    KIND_RO  = 2'd1,
    KIND_W1C = 2'd2
  } reg_kind_e;

  // Read-only takes priority if a register is flagged as both kinds.
  function automatic reg_kind_e kind_of(input logic ro, input logic w1c);
    if (ro)
      return KIND_RO;
    else if (w1c)
      return KIND_W1C;
    else
      return KIND_RW;
  endfunction

  // Register index from a byte address; lsb = log2(bytes per register).
  // Low byte-offset bits are simply dropped.
  function automatic int unsigned idx_of(input logic [ADDR_MAX_W-1:0] addr,
                                         input int unsigned           lsb);
    return addr >> lsb;
  endfunction

  // Expand byte strobes into a per-bit write mask.
  function automatic logic [DATA_MAX_W-1:0] strb_mask(input logic [STRB_MAX_W-1:0] wstrb);
    logic [DATA_MAX_W-1:0] m;
    m = '0;
    for (int unsigned b = 0; b < STRB_MAX_W; b++)
      m[b*8 +: 8] = {8{wstrb[b]}};
    return m;
  endfunction

  // Write response for an access whose index is or is not decoded.
  function automatic logic [1:0] resp_of(input logic in_range);
    return in_range ? OKAY : SLVERR;
  endfunction

endpackage

// File: rtl/handler_axil_regs.sv
// handler_axil_regs
//   Parametrised AXI4-Lite register-file slave with byte strobes,
//   independent AW/W capture, read-only and write-1-to-clear registers,
//   and SLVERR on out-of-range accesses.
//
// Ports
//   ACLK, ARESET          clock, asynchronous active-high reset
//   S_AXI_AW*             write address channel (AWPROT ignored)
//   S_AXI_W*              write data channel with byte strobes
//   S_AXI_B*              write response channel
//   S_AXI_AR*             read address channel (ARPROT ignored)
//   S_AXI_R*              read data channel
//   hw_val                live values returned when reading RO registers
//   hw_set                per-bit set strobes for W1C registers
//   reg_out               flat register contents, slice i = register i
//   wr_pulse              one-cycle pulse per committed in-range write
module handler_axil_regs
  import handler_axil_pkg::*;
#(
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          NUM_REGS = 4,
  parameter int unsigned          ADDR_W   = 8,
  parameter logic [NUM_REGS-1:0]  RO_MASK  = '0,
  parameter logic [NUM_REGS-1:0]  W1C_MASK = '0
) (
  input  logic                         ACLK,
  input  logic                         ARESET,

  input  logic [ADDR_W-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                   S_AXI_AWPROT,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,

  input  logic [DATA_W-1:0]            S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]          S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,

  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,

  input  logic [ADDR_W-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                   S_AXI_ARPROT,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,

  output logic [DATA_W-1:0]            S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,

  input  logic [NUM_REGS*DATA_W-1:0]   hw_val,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_set,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);

  // Write-side state
  logic                       aw_held;
  logic [ADDR_W-1:0]          aw_addr_q;
  logic                       w_held;
  logic [DATA_W-1:0]          w_data_q;
  logic [STRB_W-1:0]          w_strb_q;
  logic                       bvalid;
  logic [1:0]                 bresp;

  // Read-side state
  logic                       rvalid;
  logic [1:0]                 rresp;
  logic [DATA_W-1:0]          rdata;

  // Register file
  logic [NUM_REGS*DATA_W-1:0] regs_q;
  logic [NUM_REGS*DATA_W-1:0] regs_d;
  logic [NUM_REGS-1:0]        pulse_q;
  logic [NUM_REGS-1:0]        pulse_d;

  // Write decode
  logic                       aw_hs;
  logic                       w_hs;
  logic                       commit;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic [STRB_W-1:0]          wr_strb;
  logic [DATA_MAX_W-1:0]      wr_mask_full;
  logic [DATA_W-1:0]          wr_bits;
  int unsigned                wr_idx;
  logic                       wr_in_range;

  // Read decode
  logic                       ar_hs;
  int unsigned                rd_idx;
  logic                       rd_in_range;
  logic [DATA_W-1:0]          rd_val;

  // Per-register scratch for the next-state loop
  logic [DATA_W-1:0]          cur;
  logic [DATA_W-1:0]          nxt;
  logic                       hit;

  logic                       unused;

  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, hw_set, hw_val, wr_mask_full};

  // Readies are forced low while reset is asserted so nothing is accepted
  // during reset, then come up in the first cycle after release.
  assign S_AXI_AWREADY = !ARESET && !aw_held && !bvalid;
  assign S_AXI_WREADY  = !ARESET && !w_held  && !bvalid;
  assign S_AXI_ARREADY = !ARESET && !rvalid;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // A beat is taken from the holding register if it arrived earlier,
  // otherwise straight from the bus in the cycle its handshake completes.
  assign wr_addr = aw_held ? aw_addr_q : S_AXI_AWADDR;
  assign wr_data = w_held  ? w_data_q  : S_AXI_WDATA;
  assign wr_strb = w_held  ? w_strb_q  : S_AXI_WSTRB;
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs);

  assign wr_idx       = idx_of(ADDR_MAX_W'(wr_addr), LSB);
  assign wr_in_range  = wr_idx < NUM_REGS;
  assign wr_mask_full = strb_mask(STRB_MAX_W'(wr_strb));
  assign wr_bits      = DATA_W'(wr_mask_full);

  assign rd_idx      = idx_of(ADDR_MAX_W'(S_AXI_ARADDR), LSB);
  assign rd_in_range = rd_idx < NUM_REGS;

  // Write channel: AW/W holding registers and the B response.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held   <= 1'b0;
      aw_addr_q <= '0;
      w_held    <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid    <= 1'b0;
      bresp     <= OKAY;
    end else begin
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= resp_of(wr_in_range);
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= S_AXI_WDATA;
          w_strb_q <= S_AXI_WSTRB;
        end
        if (bvalid && S_AXI_BREADY)
          bvalid <= 1'b0;
      end
    end
  end

  // Next register contents. W1C sets are ORed in after the clear so a
  // set and a clear on the same bit in the same cycle leave the bit set.
  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    cur     = '0;
    nxt     = '0;
    hit     = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cur = regs_q[i*DATA_W +: DATA_W];
      hit = commit && wr_in_range && (wr_idx == i);
      unique case (kind_of(RO_MASK[i], W1C_MASK[i]))
        KIND_RO:  nxt = cur;
        KIND_W1C: nxt = (hit ? (cur & ~(wr_data & wr_bits)) : cur)
                        | hw_set[i*DATA_W +: DATA_W];
        default:  nxt = hit ? ((cur & ~wr_bits) | (wr_data & wr_bits)) : cur;
      endcase
      regs_d[i*DATA_W +: DATA_W] = nxt;
      pulse_d[i]                 = hit;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      regs_q  <= '0;
      pulse_q <= '0;
    end else begin
      regs_q  <= regs_d;
      pulse_q <= pulse_d;
    end
  end

  // Read mux over the pre-update contents, so a read racing a commit
  // returns the old value.
  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == i)
        rd_val = RO_MASK[i] ? hw_val[i*DATA_W +: DATA_W] : regs_q[i*DATA_W +: DATA_W];
    end
  end

  // Read channel: one outstanding read, data held until RREADY.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid <= 1'b0;
      rresp  <= OKAY;
      rdata  <= '0;
    end else begin
      if (ar_hs) begin
        rvalid <= 1'b1;
        rresp  <= resp_of(rd_in_range);
        rdata  <= rd_in_range ? rd_val : '0;
      end else if (rvalid && S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  assign S_AXI_BVALID = bvalid;
  assign S_AXI_BRESP  = bresp;
  assign S_AXI_RVALID = rvalid;
  assign S_AXI_RRESP  = rresp;
  assign S_AXI_RDATA  = rdata;
  assign reg_out      = regs_q;
  assign wr_pulse     = pulse_q;

endmodule
